// File: rtl/n64_controller_link_if.sv
// Signal bundle between the N64 controller link engine and its user.
// The link engine takes the slave modport; the user / line side takes master.
interface n64_controller_link_if;
  logic        polling_enable;
  logic        controller_reset;
  logic        data_in;
  logic        data_oe;
  logic [31:0] button_data;
  logic        data_valid;
  logic        link_error;
  logic        busy;
  logic [7:0]  err_count;

  modport master (
    output polling_enable, controller_reset, data_in,
    input  data_oe, button_data, data_valid, link_error, busy, err_count
  );

  modport slave (
    input  polling_enable, controller_reset, data_in,
    output data_oe, button_data, data_valid, link_error, busy, err_count
  );
endinterface

// File: rtl/n64_controller_link.sv
// N64 controller single-wire link: sends 0x01 poll / 0xFF reset commands,
// receives the response frame and publishes the 32-bit button word.
// Optional feature macro: N64_ERR_COUNT_EN (saturating link error counter).
module n64_controller_link #(
  parameter int US_CYCLES       = 100,
  parameter int POLL_GAP_US     = 1000,
  parameter int RESP_TIMEOUT_US = 100,
  parameter int END_IDLE_US     = 8
) (
  input  logic                   PCLK,
  input  logic                   PRESERN,
  n64_controller_link_if.slave   link
);

  localparam logic [23:0] SHORT_T   = 24'(US_CYCLES);
  localparam logic [23:0] LONG_T    = 24'(3 * US_CYCLES);
  localparam logic [23:0] BIT_T     = 24'(4 * US_CYCLES);
  localparam logic [23:0] SAMPLE_T  = 24'(2 * US_CYCLES);
  localparam logic [23:0] TIMEOUT_T = 24'(RESP_TIMEOUT_US * US_CYCLES);
  localparam logic [23:0] END_T     = 24'(END_IDLE_US * US_CYCLES);
  localparam logic [23:0] GAP_T     = 24'(POLL_GAP_US * US_CYCLES);

  // The inter-poll gap is the longest interval and must fit the 24-bit timer.
  if ((64'(POLL_GAP_US) * 64'(US_CYCLES)) >= 64'd16777216) begin : g_gap_check
    $error("POLL_GAP_US*US_CYCLES does not fit the 24-bit timer");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_TX_BIT, ST_TX_STOP, ST_RX_WAIT, ST_RX_BIT, ST_GAP
  } state_t;

  state_t      state_reg;
  logic [1:0]  sync_reg;
  logic        line_prev_reg;
  logic [7:0]  cmd_reg;
  logic [2:0]  tx_idx_reg;
  logic [23:0] timer_reg;
  logic [5:0]  bit_cnt_reg;
  logic [32:0] shift_reg;
  logic        sampled_reg;
  logic        rst_sent_reg;
  logic        data_oe_reg;
  logic [31:0] button_reg;
  logic        valid_reg;
  logic        error_reg;

  logic        line;
  logic        line_fall;
  logic [23:0] tx_low_t;

  assign line      = sync_reg[1];
  assign line_fall = line_prev_reg & ~line;
  // A '1' bit is a short low pulse, a '0' bit a long one.
  assign tx_low_t  = cmd_reg[3'd7 - tx_idx_reg] ? SHORT_T : LONG_T;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      sync_reg      <= 2'b11;
      line_prev_reg <= 1'b1;
    end else begin
      sync_reg      <= {sync_reg[0], link.data_in};
      line_prev_reg <= sync_reg[1];
    end
  end

  // Transaction FSM: command transmit, response receive, inter-poll gap.
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= '0;
      tx_idx_reg   <= '0;
      timer_reg    <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      sampled_reg  <= 1'b0;
      rst_sent_reg <= 1'b0;
      data_oe_reg  <= 1'b0;
      button_reg   <= '0;
      valid_reg    <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
      if (!link.controller_reset) begin
        rst_sent_reg <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          timer_reg  <= '0;
          tx_idx_reg <= '0;
          if (link.controller_reset && !rst_sent_reg) begin
            cmd_reg      <= 8'hFF;
            rst_sent_reg <= 1'b1;
            data_oe_reg  <= 1'b1;
            state_reg    <= ST_TX_BIT;
          end else if (link.polling_enable) begin
            cmd_reg     <= 8'h01;
            data_oe_reg <= 1'b1;
            state_reg   <= ST_TX_BIT;
          end
        end
        ST_TX_BIT: begin
          if (timer_reg == BIT_T - 24'd1) begin
            timer_reg   <= '0;
            data_oe_reg <= 1'b1;
            if (tx_idx_reg == 3'd7) begin
              state_reg <= ST_TX_STOP;
            end else begin
              tx_idx_reg <= tx_idx_reg + 3'd1;
            end
          end else begin
            timer_reg <= timer_reg + 24'd1;
            if (timer_reg == tx_low_t - 24'd1) begin
              data_oe_reg <= 1'b0;
            end
          end
        end
        ST_TX_STOP: begin
          if (timer_reg == SHORT_T - 24'd1) begin
            data_oe_reg <= 1'b0;
            timer_reg   <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            state_reg   <= ST_RX_WAIT;
          end else begin
            timer_reg <= timer_reg + 24'd1;
          end
        end
        ST_RX_WAIT: begin
          if (line_fall) begin
            timer_reg   <= '0;
            sampled_reg <= 1'b0;
            state_reg   <= ST_RX_BIT;
          end else if (timer_reg == TIMEOUT_T - 24'd1) begin
            error_reg <= 1'b1;
            timer_reg <= '0;
            state_reg <= ST_GAP;
          end else begin
            timer_reg <= timer_reg + 24'd1;
          end
        end
        ST_RX_BIT: begin
          // Before the sample the timer measures edge-to-sample time;
          // after it, it measures how long the line has been high.
          if (line_fall) begin
            timer_reg   <= '0;
            sampled_reg <= 1'b0;
          end else if (!sampled_reg) begin
            if (timer_reg == SAMPLE_T - 24'd1) begin
              shift_reg   <= {shift_reg[31:0], line};
              bit_cnt_reg <= (bit_cnt_reg == 6'd63) ? 6'd63 : bit_cnt_reg + 6'd1;
              sampled_reg <= 1'b1;
              timer_reg   <= '0;
            end else begin
              timer_reg <= timer_reg + 24'd1;
            end
          end else if (!line) begin
            timer_reg <= '0;
          end else if (timer_reg == END_T - 24'd1) begin
            if (cmd_reg == 8'h01) begin
              if (bit_cnt_reg == 6'd33) begin
                button_reg <= shift_reg[32:1];
                valid_reg  <= 1'b1;
              end else begin
                error_reg <= 1'b1;
              end
            end
            timer_reg <= '0;
            state_reg <= ST_GAP;
          end else begin
            timer_reg <= timer_reg + 24'd1;
          end
        end
        ST_GAP: begin
          data_oe_reg <= 1'b0;
          if (timer_reg == GAP_T - 24'd1) begin
            timer_reg <= '0;
            state_reg <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg + 24'd1;
          end
        end
        default: begin
          data_oe_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign link.data_oe     = data_oe_reg;
  assign link.button_data = button_reg;
  assign link.data_valid  = valid_reg;
  assign link.link_error  = error_reg;
  assign link.busy        = (state_reg != ST_IDLE);

`ifdef N64_ERR_COUNT_EN
  logic [7:0] err_count_reg;

  // Saturating count of link_error pulses.
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      err_count_reg <= '0;
    end else if (error_reg && (err_count_reg != 8'hFF)) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign link.err_count = err_count_reg;
`else
  assign link.err_count = 8'h00;
`endif

endmodule

// File: tb/tb_n64_controller_link.sv
// Directed bench for n64_controller_link with a behavioural controller model
// on the open-drain line and a scoreboard of expected button words.
module tb_n64_controller_link;

  localparam int US     = 8;
  localparam int GAP_US = 50;
  localparam int TO_US  = 100;
  localparam int END_US = 8;
  localparam int GAP_T  = GAP_US * US;
  localparam int TO_T   = TO_US * US;
`ifdef N64_ERR_COUNT_EN
  localparam int ERRCNT = 1;
`else
  localparam int ERRCNT = 0;
`endif

  logic PCLK;
  logic PRESERN;
  logic ctrl_low;

  n64_controller_link_if bus ();

  n64_controller_link #(
    .US_CYCLES       (US),
    .POLL_GAP_US     (GAP_US),
    .RESP_TIMEOUT_US (TO_US),
    .END_IDLE_US     (END_US)
  ) dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .link    (bus)
  );

  // Wired-AND open-drain line: either side may pull it low.
  assign bus.data_in = ~(bus.data_oe | ctrl_low);

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_pulses = 0;
  int last_valid_cyc = 0;
  int last_err_cyc = 0;
  int rise_cyc = 0;
  int end_cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  always @(posedge PCLK) cyc <= cyc + 1;

  // Output monitor: captures published words and error pulses.
  always @(negedge PCLK) begin
    if (bus.data_valid === 1'b1) begin
      got_q.push_back(bus.button_data);
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (bus.link_error === 1'b1) begin
      err_pulses++;
      last_err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_range(input string tag, input int got, input int lo, input int hi);
    total++;
    assert (got >= lo && got <= hi) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d..%0d", tag, got, lo, hi);
    end
  endtask

  // Decode one command frame from data_oe pulse widths.
  task automatic capture(output logic [7:0] cmd, output bit ok);
    int hw;
    int lw;
    int w;
    ok = 1'b1;
    cmd = 8'h00;
    w = 0;
    while (bus.data_oe !== 1'b1 && w < GAP_T + 40 * US) begin
      @(negedge PCLK);
      w++;
    end
    if (bus.data_oe !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    rise_cyc = cyc;
    for (int i = 0; i < 9; i++) begin
      hw = 0;
      while (bus.data_oe === 1'b1 && hw < 4 * US) begin
        @(negedge PCLK);
        hw++;
      end
      if (i < 8) begin
        lw = 0;
        while (bus.data_oe === 1'b0 && lw < 4 * US) begin
          @(negedge PCLK);
          lw++;
        end
        if (hw == US && lw == 3 * US) cmd[7 - i] = 1'b1;
        else if (hw == 3 * US && lw == US) cmd[7 - i] = 1'b0;
        else ok = 1'b0;
      end else if (hw != US) begin
        ok = 1'b0;
      end
    end
    end_cyc = cyc;
  endtask

  // Controller model reply: n bits from bits[n-1] down to bits[0].
  task automatic reply(input logic [32:0] bits, input int n);
    int lo;
    repeat (2 * US) @(negedge PCLK);
    for (int i = n - 1; i >= 0; i--) begin
      lo = bits[i] ? US : 3 * US;
      ctrl_low = 1'b1;
      repeat (lo) @(negedge PCLK);
      ctrl_low = 1'b0;
      repeat (4 * US - lo) @(negedge PCLK);
    end
  endtask

  task automatic expect_frame(input string tag);
    int w;
    logic [31:0] e;
    w = 0;
    while (got_q.size() == 0 && w < 20 * US) begin
      @(negedge PCLK);
      w++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    if (got_q.size() == 0) begin
      check({tag, "_valid_seen"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_button"}, got_q.pop_front(), e);
    end
    $display("txn %s poll reply expected=%h button_data=%h", tag, e, bus.button_data);
  endtask

  task automatic wait_err(input int n);
    int w;
    w = 0;
    while (err_pulses < n && w < TO_T + 40 * US) begin
      @(negedge PCLK);
      w++;
    end
  endtask

  logic [7:0] cmd;
  bit ok;
  int w;
  int rises;
  logic oe_prev;

  initial begin
    PRESERN = 1'b1;
    ctrl_low = 1'b0;
    bus.polling_enable = 1'b0;
    bus.controller_reset = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_data_oe", 32'(bus.data_oe), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_button", bus.button_data, 32'd0);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_error", 32'(bus.link_error), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    PRESERN = 1'b0;
    repeat (4) @(negedge PCLK);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Poll with a good 32-bit reply.
    bus.polling_enable = 1'b1;
    capture(cmd, ok);
    check("t1_cmd", 32'(cmd), 32'h01);
    check("t1_widths", 32'(ok), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd1);
    exp_q.push_back(32'h8000_00FF);
    reply({32'h8000_00FF, 1'b1}, 33);
    expect_frame("t1");
    check("t1_valid_cnt", 32'(valid_cnt), 32'd1);
    check("t1_err_pulses", 32'(err_pulses), 32'd0);

    // Next poll after the gap, left unanswered.
    capture(cmd, ok);
    check("t2_cmd", 32'(cmd), 32'h01);
    check("t2_widths", 32'(ok), 32'd1);
    check_range("t2_gap_cycles", rise_cyc - last_valid_cyc, GAP_T, GAP_T + 2);
    wait_err(1);
    check("t2_err_pulses", 32'(err_pulses), 32'd1);
    check_range("t2_timeout_cycles", last_err_cyc - end_cyc, TO_T - 1, TO_T + 1);
    repeat (3) @(negedge PCLK);
    check("t2_button_held", bus.button_data, 32'h8000_00FF);
    check("t2_err_count", 32'(bus.err_count), 32'(ERRCNT * 1));
    $display("txn t2 poll no reply err_pulses=%0d", err_pulses);

    // Poll answered with only 31 data bits plus stop.
    capture(cmd, ok);
    check("t3_cmd", 32'(cmd), 32'h01);
    reply(33'({31'h2AAA_5555, 1'b1}), 32);
    wait_err(2);
    repeat (3) @(negedge PCLK);
    check("t3_err_pulses", 32'(err_pulses), 32'd2);
    check("t3_button_held", bus.button_data, 32'h8000_00FF);
    check("t3_valid_cnt", 32'(valid_cnt), 32'd1);
    check("t3_err_count", 32'(bus.err_count), 32'(ERRCNT * 2));
    $display("txn t3 poll short reply err_pulses=%0d", err_pulses);

    // Reset command held high alongside polling: one 0xFF, then polls.
    bus.controller_reset = 1'b1;
    capture(cmd, ok);
    check("t4_cmd", 32'(cmd), 32'hFF);
    check("t4_widths", 32'(ok), 32'd1);
    reply({32'h1234_5678, 1'b1}, 33);
    repeat (END_US * US + 20) @(negedge PCLK);
    check("t4_no_valid", 32'(got_q.size()), 32'd0);
    check("t4_no_error", 32'(err_pulses), 32'd2);
    $display("txn t4 reset cmd=%h", cmd);
    capture(cmd, ok);
    check("t5_cmd", 32'(cmd), 32'h01);
    exp_q.push_back(32'h0F0F_1234);
    reply({32'h0F0F_1234, 1'b1}, 33);
    expect_frame("t5");

    // Reset in the middle of the next command transmission.
    w = 0;
    while (bus.data_oe !== 1'b1 && w < GAP_T + 40 * US) begin
      @(negedge PCLK);
      w++;
    end
    check("t6_tx_started", 32'(bus.data_oe), 32'd1);
    repeat (5) @(negedge PCLK);
    PRESERN = 1'b1;
    @(negedge PCLK);
    check("t6_data_oe", 32'(bus.data_oe), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_button", bus.button_data, 32'd0);
    check("t6_valid", 32'(bus.data_valid), 32'd0);
    check("t6_err_count", 32'(bus.err_count), 32'd0);
    PRESERN = 1'b0;
    bus.controller_reset = 1'b0;
    bus.polling_enable = 1'b0;
    repeat (20) @(negedge PCLK);
    check("t6_idle_busy", 32'(bus.busy), 32'd0);
    $display("txn t6 reset mid-transmit");

    // Dropping polling_enable mid-transaction still completes it.
    bus.polling_enable = 1'b1;
    capture(cmd, ok);
    bus.polling_enable = 1'b0;
    check("t7_cmd", 32'(cmd), 32'h01);
    exp_q.push_back(32'hCAFE_0001);
    reply({32'hCAFE_0001, 1'b1}, 33);
    expect_frame("t7");
    rises = 0;
    oe_prev = bus.data_oe;
    repeat (GAP_T + 20 * US) begin
      @(negedge PCLK);
      if (bus.data_oe === 1'b1 && oe_prev !== 1'b1) rises++;
      oe_prev = bus.data_oe;
    end
    check("t7_no_new_cmd", 32'(rises), 32'd0);
    check("t7_busy", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/n64_controller_link.md
N64_CONTROLLER_LINK -- requirements
Module: n64_controller_link

Interface
REQ-001 Parameter US_CYCLES, default 100: PCLK cycles per microsecond.
REQ-002 Parameter POLL_GAP_US, default 1000: idle time between the end of one transaction and the next command, in microseconds.
REQ-003 Parameter RESP_TIMEOUT_US, default 100: maximum wait for the first response falling edge, in microseconds.
REQ-004 Parameter END_IDLE_US, default 8: line-high time that ends a response frame, in microseconds.
REQ-005 Port PCLK, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port PRESERN, input, 1: reset, synchronous and active-high.
REQ-007 Port polling_enable, input, 1: high enables continuous 0x01 poll commands.
REQ-008 Port controller_reset, input, 1: high requests one 0xFF reset command.
REQ-009 Port data_in, input, 1: raw level of the controller data line, asynchronous to PCLK.
REQ-010 Port data_oe, output, 1: 1 drives the open-drain line low; 0 releases it.
REQ-011 Port button_data, output, 32: last valid poll response, MSB = first received bit.
REQ-012 Port data_valid, output, 1: one-cycle pulse when button_data updates.
REQ-013 Port link_error, output, 1: one-cycle pulse on a timeout or a bad bit count.
REQ-014 Port busy, output, 1: high in any state other than IDLE.
REQ-015 Port err_count, output, 8: saturating error counter (see Configuration).

Function
REQ-016 data_in SHALL pass through a 2-flop synchronizer before any use.
REQ-017 FSM states SHALL be IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT and GAP.
REQ-018 In IDLE, the block SHALL select a command as follows:
- controller_reset high with rst_sent clear: 0xFF, and set rst_sent.
- otherwise, polling_enable high: 0x01.
- otherwise: stay in IDLE.
- controller_reset has priority over polling_enable.
REQ-019 rst_sent SHALL clear whenever controller_reset is low, so each high level yields exactly one 0xFF.
REQ-020 TX_BIT SHALL send 8 bits MSB first, each 4 us:
- bit 0: data_oe=1 for 3 us, then 0 for 1 us.
- bit 1: data_oe=1 for 1 us, then 0 for 3 us.
REQ-021 TX_STOP SHALL drive data_oe=1 for 1 us, then release the line and enter RX_WAIT.
REQ-022 RX_WAIT SHALL enter RX_BIT on a synchronized falling edge.
REQ-023 If no falling edge arrives within RESP_TIMEOUT_US, RX_WAIT SHALL pulse link_error and enter GAP.
REQ-024 RX_BIT SHALL sample the line 2 us after each falling edge, shift the sample in as the bit value, and increment bit_cnt (6-bit, saturating at 63).
REQ-025 The frame SHALL end when the line stays high for END_IDLE_US after the last sample.
REQ-026 At frame end for a 0x01 command, the block SHALL act on bit_cnt:
- bit_cnt==33 (32 data bits + stop): load the first 32 bits into button_data and pulse data_valid, both in the same cycle.
- any other count: pulse link_error and hold button_data.
REQ-027 At frame end for a 0xFF command, the response SHALL be discarded with no data_valid and no link_error.
REQ-028 GAP SHALL keep data_oe=0 for POLL_GAP_US, then return to IDLE.
REQ-029 data_oe SHALL be 0 in RX_WAIT, RX_BIT, GAP and IDLE.
REQ-030 A drop of polling_enable mid-transaction SHALL NOT abort the transaction; the block SHALL finish it and go idle after GAP.
REQ-031 Timing counters SHALL be 24-bit.
REQ-032 Elaboration SHALL check that POLL_GAP_US*US_CYCLES < 2^24.

Reset
REQ-033 With PRESERN high at a clock edge, the following SHALL hold on the next cycle:
- state=IDLE, data_oe=0, button_data=0, data_valid=0, link_error=0, busy=0.
- err_count=0, rst_sent=0, all counters=0.
REQ-034 Reset SHALL override any in-progress transaction immediately; the line is released within one cycle.

Configuration
REQ-035 With N64_ERR_COUNT_EN defined, err_count SHALL increment on each link_error pulse and saturate at 255.
REQ-036 With N64_ERR_COUNT_EN undefined, err_count SHALL be constant 0 and the counter logic SHALL be omitted.

Verification
REQ-037 Reset then polling_enable=1 -> data_oe low pattern 300/100 ×7 then 100/300 (0x01), then 100 low; busy=1.
REQ-038 Controller model returns 0x8000_00FF + stop -> button_data=0x800000FF, one data_valid pulse, then 100000 idle cycles before next command.
REQ-039 controller_reset=1 held with polling_enable=1 -> exactly one 0xFF frame, then only 0x01 frames; no data_valid for the 0xFF reply.
REQ-040 No response after command -> link_error pulse at 10000 cycles after stop; err_count=1 with N64_ERR_COUNT_EN; button_data unchanged.
REQ-041 Model returns 31 bits + stop -> link_error, button_data held.
REQ-042 PRESERN pulsed mid-TX_BIT -> data_oe=0 next cycle, state IDLE, all outputs at reset values.
